// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU with single-cycle logic/add/sub/slt
// and a WIDTH-cycle iterative shift-add multiply that stalls upstream.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous reset, active-low
//   valid_i    operation present on ALUCtrl_i/src1_i/src2_i
//   flush_i    squash accepted/in-flight operation
//   ALUCtrl_i  4-bit operation code
//   src1_i     operand A
//   src2_i     operand B
//   result_o   registered result
//   zero_o     registered, result_o == 0
//   done_o     one-cycle pulse when result_o/zero_o are written
//   stall_o    combinational, upstream must hold ID/EX
module ex_alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             done_o,
    output logic             stall_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_ADDI = 4'b1010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_BEQ  = 4'b1110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTI = 4'b1111;
    localparam logic [3:0] OP_MUL  = 4'b0011;

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_sum;
    logic             accept;
    logic             start_mul;

    // Single-cycle datapath; unknown codes fall through to 0.
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:           alu_res = src1_i & src2_i;
            OP_OR:            alu_res = src1_i | src2_i;
            OP_ADD, OP_ADDI:  alu_res = src1_i + src2_i;
            OP_SUB, OP_BEQ:   alu_res = src1_i - src2_i;
            OP_SLT, OP_SLTI:  alu_res = {{(WIDTH-1){1'b0}},
                                         $signed(src1_i) < $signed(src2_i)};
            default:          alu_res = '0;
        endcase
    end

    assign accept    = (state_q == S_IDLE) & valid_i & ~flush_i;
    assign start_mul = accept & (ALUCtrl_i == OP_MUL);

    // Partial sum including this cycle's multiplier bit.
    assign mul_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_mul) begin
                    mcand_d  = src1_i;
                    mplier_d = src2_i;
                    prod_d   = '0;
                    cnt_d    = '0;
                    state_d  = S_MUL;
                end else if (accept) begin
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    done_d   = 1'b1;
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d   = mul_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        result_d = mul_sum;
                        zero_d   = (mul_sum == '0);
                        done_d   = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign done_o   = done_q;
    // Gated by reset so the hazard unit never sees a stale stall.
    assign stall_o  = rst_i & ((state_q == S_MUL) | start_mul);

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed and randomized checks of ex_alu_unit
// against a cycle-level behavioural model.
module tb_ex_alu_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         flush_i = 1'b0;
    logic [3:0]   op_i = 4'b0000;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         done_o;
    logic         stall_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // model state
    int           m_busy = 0;
    logic [W-1:0] m_prod = '0;
    logic [W-1:0] m_res = '0;
    logic         m_zero = 1'b0;
    logic         m_done = 1'b0;

    ex_alu_unit #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .ALUCtrl_i (op_i),
        .src1_i    (a_i),
        .src2_i    (b_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .done_o    (done_o),
        .stall_o   (stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010, 4'b1010: return a + b;
            4'b0110, 4'b1110: return a - b;
            4'b0111, 4'b1111:
                return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // Called right after each rising edge, inputs still as sampled.
    task automatic model_edge();
        m_done = 1'b0;
        if (!rst_i) begin
            m_busy = 0;
            m_res  = '0;
            m_zero = 1'b0;
        end else if (m_busy > 0) begin
            if (flush_i) begin
                m_busy = 0;
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_res  = m_prod;
                    m_zero = (m_prod == 0);
                    m_done = 1'b1;
                end
            end
        end else if (valid_i && !flush_i) begin
            if (op_i == 4'b0011) begin
                m_prod = a_i * b_i;
                m_busy = W;
            end else begin
                m_res  = ref_alu(op_i, a_i, b_i);
                m_zero = (m_res == 0);
                m_done = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("result", result_o, m_res);
            chk("zero", W'(zero_o), W'(m_zero));
            chk("done", W'(done_o), W'(m_done));
            chk("stall", W'(stall_o),
                W'(rst_i && (m_busy > 0 ||
                   (valid_i && !flush_i && op_i == 4'b0011))));
        end
    end

    task automatic step(input logic v, input logic f,
                        input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = v;
        flush_i = f;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'b0000, '0, '0);
    endtask

    task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] req, input logic rz);
        step(1'b1, 1'b0, 4'b0011, a, b);
        for (int k = 0; k < W; k++) begin
            chk("mul_stall", W'(stall_o), 1);
            chk("mul_nodone", W'(done_o), 0);
            idle();
        end
        chk("mul_done", W'(done_o), 1);
        chk("mul_res", result_o, req);
        chk("mul_zero", W'(zero_o), W'(rz));
        chk("mul_stall_low", W'(stall_o), 0);
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 3))
            0: return W'($urandom_range(0, 15));
            1: return '0;
            2: return $urandom;
            default: return '1 - W'($urandom_range(0, 15));
        endcase
    endfunction

    logic [3:0] ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b1010,
                             4'b0110, 4'b1110, 4'b0111, 4'b1111,
                             4'b0011, 4'b0101};

    initial begin
        logic [3:0] rop;
        #1 rst_i = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_res", result_o, 0);
        chk("rst_done", W'(done_o), 0);
        chk("rst_stall", W'(stall_o), 0);
        @(posedge clk);
        #1 rst_i = 1'b1;

        step(1'b1, 1'b0, 4'b0010, 5, 7);
        chk("add_res", result_o, 12);
        chk("add_zero", W'(zero_o), 0);
        chk("add_done", W'(done_o), 1);
        chk("model_add", m_res, 12);
        step(1'b1, 1'b0, 4'b1110, 32'h1234, 32'h1234);
        chk("beq_res", result_o, 0);
        chk("beq_zero", W'(zero_o), 1);

        step(1'b1, 1'b0, 4'b0000, 32'hF0F0, 32'h0FF0);
        chk("and_res", result_o, 32'h00F0);
        chk("and_done", W'(done_o), 1);
        step(1'b1, 1'b0, 4'b0001, 32'hF0F0, 32'h0FF0);
        chk("or_res", result_o, 32'hFFF0);
        chk("or_done", W'(done_o), 1);
        step(1'b1, 1'b0, 4'b0111, 32'hFFFF_FFFF, 1);
        chk("slt_res", result_o, 1);
        chk("slt_done", W'(done_o), 1);
        chk("model_slt", m_res, 1);
        idle();
        chk("done_drop", W'(done_o), 0);

        run_mul(7, 6, 42, 1'b0);
        run_mul(32'hFFFF_FFFD, 5, 32'hFFFF_FFF1, 1'b0);
        chk("model_mul", m_res, 32'hFFFF_FFF1);
        run_mul(32'h10000, 32'h10000, 0, 1'b1);

        step(1'b1, 1'b0, 4'b0010, 1, 1);
        step(1'b1, 1'b0, 4'b0011, 3, 3);
        for (int k = 0; k < 9; k++) idle();
        chk("fl_pre_stall", W'(stall_o), 1);
        step(1'b0, 1'b1, 4'b0000, '0, '0);
        chk("fl_stall", W'(stall_o), 0);
        chk("fl_done", W'(done_o), 0);
        chk("fl_res", result_o, 2);
        step(1'b1, 1'b0, 4'b0010, 4, 5);
        chk("fl_add", result_o, 9);
        chk("fl_add_done", W'(done_o), 1);

        step(1'b1, 1'b0, 4'b0011, 5, 5);
        for (int k = 0; k < 5; k++) idle();
        #2 rst_i = 1'b0;
        #1;
        model_edge();
        chk("rm_res", result_o, 0);
        chk("rm_zero", W'(zero_o), 0);
        chk("rm_done", W'(done_o), 0);
        chk("rm_stall", W'(stall_o), 0);
        @(posedge clk);
        #1 rst_i = 1'b1;
        step(1'b1, 1'b0, 4'b0010, 2, 3);
        chk("rm_add", result_o, 5);
        chk("rm_add_done", W'(done_o), 1);

        step(1'b1, 1'b0, 4'b0101, 9, 9);
        chk("undef_res", result_o, 0);
        chk("undef_zero", W'(zero_o), 1);
        chk("undef_done", W'(done_o), 1);
        valid_i = 1'b1;
        flush_i = 1'b1;
        op_i    = 4'b0011;
        #1 chk("idle_fl_stall", W'(stall_o), 0);
        step(1'b1, 1'b1, 4'b0011, 2, 2);
        chk("idle_fl_done", W'(done_o), 0);

        for (int n = 0; n < 400; n++) begin
            rop = ($urandom_range(0, 7) == 0) ?
                  4'($urandom_range(0, 15)) : ops[$urandom_range(0, 9)];
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 rop, rnd_opnd(), rnd_opnd());
        end
        for (int k = 0; k < W + 2; k++) idle();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
